level_stack: RTL and testbench



---
 rtl/level_pkg.sv | 24 ++
 rtl/frame_lifo.sv | 58 +++++
 rtl/level_stack.sv | 138 +++++++++++++
 tb/tb_level_stack.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// level_pkg: shared types for the interrupt-level tracker.
// Level, return frame and FSM state definitions.
package level_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_LEVELS = 8;
  localparam int IDX_W      = $clog2(NUM_LEVELS);

  localparam logic [DATA_W-1:0] VEC_BASE =
    32'h0000_0100;

  typedef logic [IDX_W-1:0] level_t;

  typedef struct packed {
    level_t              prev_level;
    logic [DATA_W-1:0]   ret_pc;
  } frame_t;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/frame_lifo.sv
// frame_lifo: small LIFO of return frames.
// Only the occupancy count is reset; entries are don't-care when empty.
module frame_lifo
  import level_pkg::*;
#(
  parameter int Entries = NUM_LEVELS - 1,
  parameter int DepthW  = $clog2(Entries + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  frame_t            push_data,
  output frame_t            top_data,
  output logic [DepthW-1:0] depth,
  output logic              full,
  output logic              empty
);

  frame_t            mem_q [Entries];
  frame_t            mem_d [Entries];
  logic [DepthW-1:0] depth_q;
  logic [DepthW-1:0] depth_d;

  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = (depth_q == DepthW'(Entries));

  assign top_data =
    empty ? '0 : mem_q[depth_q - DepthW'(1)];

  // Next storage and count; push wins over pop
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[depth_q] = push_data;
      depth_d        = depth_q + DepthW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DepthW'(1);
    end
  end

  // Occupancy register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Frame storage, never reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/level_stack.sv
// level_stack: current interrupt level, nesting stack and PC redirect.
// Accepts higher-priority requests and restores state on return.
module level_stack
  import level_pkg::*;
#(
  parameter int DataWidth   = DATA_W,
  parameter int NumLevels   = NUM_LEVELS,
  parameter int IndexLevels = $clog2(NumLevels),
  parameter logic [DataWidth-1:0] VecBase = VEC_BASE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   irqValid,
  input  logic [IndexLevels-1:0] irqLevel,
  output logic                   irqAck,
  input  logic [DataWidth-1:0]   curPc,
  input  logic                   retEn,
  output logic [IndexLevels-1:0] level,
  output logic                   pcLoadEn,
  output logic [DataWidth-1:0]   pcLoadData,
  output logic                   fault
);

  localparam int DepthW = $clog2(NumLevels);

  state_t               state_q;
  state_t               state_d;
  level_t               level_q;
  level_t               level_d;
  logic                 ack_q;
  logic                 ack_d;
  logic                 ld_en_q;
  logic                 ld_en_d;
  logic [DataWidth-1:0] ld_pc_q;
  logic [DataWidth-1:0] ld_pc_d;
  logic                 fault_q;
  logic                 fault_d;

  logic                 push;
  logic                 pop;
  frame_t               push_frame;
  frame_t               top_frame;
  logic [DepthW-1:0]    stk_depth;
  logic                 stk_full;
  logic                 stk_empty;
  logic                 irq_hi;

  frame_lifo #(
    .Entries (NumLevels - 1),
    .DepthW  (DepthW)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_frame),
    .top_data  (top_frame),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign irq_hi = irqValid && (irqLevel > level_q);

  assign push_frame = '{
    prev_level: level_q,
    ret_pc:     curPc
  };

  // Flags and count from the stack must agree
  always_comb begin
    assert (stk_empty == (stk_depth == '0));
  end

  // Next state: return beats interrupt; LOAD ignores both
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ack_d   = 1'b0;
    ld_en_d = 1'b0;
    ld_pc_d = ld_pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (retEn) begin
          if (!stk_empty) begin
            pop     = 1'b1;
            level_d = top_frame.prev_level;
            ld_pc_d = top_frame.ret_pc;
            ld_en_d = 1'b1;
            state_d = LOAD;
          end else begin
            fault_d = 1'b1;
          end
        end else if (irq_hi && !stk_full) begin
          push    = 1'b1;
          level_d = irqLevel;
          ld_pc_d = VecBase +
                    (DataWidth'(irqLevel) << 2);
          ld_en_d = 1'b1;
          ack_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      level_q <= '0;
      ack_q   <= 1'b0;
      ld_en_q <= 1'b0;
      ld_pc_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      ack_q   <= ack_d;
      ld_en_q <= ld_en_d;
      ld_pc_q <= ld_pc_d;
      fault_q <= fault_d;
    end
  end

  assign level      = level_q;
  assign irqAck     = ack_q;
  assign pcLoadEn   = ld_en_q;
  assign pcLoadData = ld_pc_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_level_stack.sv
// tb_level_stack: directed stimulus, queue-based model, per-cycle compare.
// Literal expectations pin the model at key points of the sequence.
module tb_level_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        irqValid;
  logic [2:0]  irqLevel;
  logic        irqAck;
  logic [31:0] curPc;
  logic        retEn;
  logic [2:0]  level;
  logic        pcLoadEn;
  logic [31:0] pcLoadData;
  logic        fault;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  level_stack dut (
    .clk        (clk),
    .reset      (reset),
    .irqValid   (irqValid),
    .irqLevel   (irqLevel),
    .irqAck     (irqAck),
    .curPc      (curPc),
    .retEn      (retEn),
    .level      (level),
    .pcLoadEn   (pcLoadEn),
    .pcLoadData (pcLoadData),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lvl;
    logic [31:0] pc;
  } mframe_t;

  mframe_t     stk[$];
  int          m_level = 0;
  bit          m_ack   = 0;
  bit          m_ld    = 0;
  logic [31:0] m_pc    = 0;
  bit          m_fault = 0;

  // Reference model: a cycle after any redirect ignores its inputs
  always @(posedge clk) begin
    mframe_t f;
    bit busy;
    if (reset) begin
      stk.delete();
      m_level = 0;
      m_ack   = 0;
      m_ld    = 0;
      m_pc    = 0;
      m_fault = 0;
    end else begin
      busy  = m_ld;
      m_ack = 0;
      m_ld  = 0;
      if (!busy) begin
        if (retEn) begin
          if (stk.size() > 0) begin
            f       = stk.pop_back();
            m_level = f.lvl;
            m_pc    = f.pc;
            m_ld    = 1;
          end else begin
            m_fault = 1;
          end
        end else if (irqValid && int'(irqLevel) > m_level
                     && stk.size() < 7) begin
          f.lvl = m_level;
          f.pc  = curPc;
          stk.push_back(f);
          m_level = int'(irqLevel);
          m_pc    = 32'h100 + 32'(irqLevel) * 4;
          m_ld    = 1;
          m_ack   = 1;
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model every cycle
  always @(negedge clk) begin
    if (started) begin
      check("level", 32'(level), 32'(m_level));
      check("irqAck", 32'(irqAck), 32'(m_ack));
      check("pcLoadEn", 32'(pcLoadEn), 32'(m_ld));
      check("pcLoadData", pcLoadData, m_pc);
      check("fault", 32'(fault), 32'(m_fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic irq(input logic [2:0] l,
                     input logic [31:0] pc);
    irqValid = 1'b1;
    irqLevel = l;
    curPc    = pc;
    tick();
    irqValid = 1'b0;
  endtask

  task automatic ret();
    retEn = 1'b1;
    tick();
    retEn = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    irqValid = 1'b0;
    irqLevel = '0;
    curPc    = '0;
    retEn    = 1'b0;
    tick();
    started = 1;
    tick();
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_level", 32'(level), 32'd0);
      check("idle_ld", 32'(pcLoadEn), 32'd0);
      check("idle_fault", 32'(fault), 32'd0);
    end

    // first accept
    irq(3'd3, 32'h200);
    check("a3_ack", 32'(irqAck), 32'd1);
    check("a3_level", 32'(level), 32'd3);
    check("a3_ld", 32'(pcLoadEn), 32'd1);
    check("a3_pc", pcLoadData, 32'h10C);
    tick();
    check("a3_ld_drop", 32'(pcLoadEn), 32'd0);
    check("a3_ack_drop", 32'(irqAck), 32'd0);

    // nest and unwind
    irq(3'd5, 32'h120);
    check("a5_level", 32'(level), 32'd5);
    check("a5_pc", pcLoadData, 32'h114);
    tick();
    ret();
    check("r1_level", 32'(level), 32'd3);
    check("r1_pc", pcLoadData, 32'h120);
    check("r1_ack", 32'(irqAck), 32'd0);
    tick();
    ret();
    check("r2_level", 32'(level), 32'd0);
    check("r2_pc", pcLoadData, 32'h200);
    tick();

    // lower request held, then tail-chained
    irq(3'd5, 32'h300);
    tick();
    irqValid = 1'b1;
    irqLevel = 3'd2;
    curPc    = 32'h340;
    tick();
    check("low_noack", 32'(irqAck), 32'd0);
    check("low_level", 32'(level), 32'd5);
    tick();
    retEn = 1'b1;
    tick();
    retEn = 1'b0;
    check("tc_level", 32'(level), 32'd0);
    check("tc_pc", pcLoadData, 32'h300);
    check("tc_noack", 32'(irqAck), 32'd0);
    tick();
    check("tc_load_noack", 32'(irqAck), 32'd0);
    tick();
    irqValid = 1'b0;
    check("tc_ack", 32'(irqAck), 32'd1);
    check("tc_level2", 32'(level), 32'd2);
    check("tc_pc2", pcLoadData, 32'h108);
    tick();
    ret();
    check("tc_ret_pc", pcLoadData, 32'h340);
    tick();

    // ret held through the LOAD cycle is ignored there
    irq(3'd1, 32'h500);
    retEn = 1'b1;
    tick();
    check("load_ign_level", 32'(level), 32'd1);
    tick();
    retEn = 1'b0;
    check("held_ret_level", 32'(level), 32'd0);
    tick();

    // full nesting 1..7, equal level refused, then unwind
    for (int l = 1; l < 8; l++) begin
      irq(3'(l), 32'h1000 + 32'(l) * 32'h10);
      tick();
    end
    check("n7_pc", pcLoadData, 32'h11C);
    irqValid = 1'b1;
    irqLevel = 3'd7;
    tick();
    irqValid = 1'b0;
    check("eq_noack", 32'(irqAck), 32'd0);
    for (int l = 0; l < 7; l++) begin
      ret();
      tick();
    end
    check("unw_level", 32'(level), 32'd0);
    check("unw_pc", pcLoadData, 32'h1010);

    // return with empty stack
    ret();
    check("flt_set", 32'(fault), 32'd1);
    check("flt_level", 32'(level), 32'd0);
    check("flt_ld", 32'(pcLoadEn), 32'd0);
    irq(3'd6, 32'h600);
    tick();
    check("flt_sticky", 32'(fault), 32'd1);
    ret();
    tick();

    // reset during LOAD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_fault", 32'(fault), 32'd0);
    irq(3'd4, 32'h700);
    check("r4_ack", 32'(irqAck), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rl_level", 32'(level), 32'd0);
    check("rl_ld", 32'(pcLoadEn), 32'd0);
    check("rl_pc", pcLoadData, 32'd0);
    ret();
    check("rl_empty_fault", 32'(fault), 32'd1);
    check("rl_empty_ld", 32'(pcLoadEn), 32'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
